div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 127 ++++++++++++
 tb/tb_div_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Pipeline-side bundle for the iterative divider: request, operands, flush, stall and result.
// The pipeline drives through master; div_unit receives through slave.
interface div_unit_if;
    logic        div_start;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic        stallreq_for_ex;
    logic        ready;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    modport master (
        output div_start, signed_div, opdata1, opdata2, annul,
        input  stallreq_for_ex, ready, result_lo, result_hi
    );

    modport slave (
        input  div_start, signed_div, opdata1, opdata2, annul,
        output stallreq_for_ex, ready, result_lo, result_hi
    );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for div/divu, 32 iterations, with flush and divide-by-zero path.
// Optional DIV_ZERO_SKIP_EN: a zero dividend short-cuts through BYZERO as well.
module div_unit (
    input  logic       clk,
    input  logic       rst,
    div_unit_if.slave  bus
);
    typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [31:0] result_lo_q, result_lo_d;
    logic [31:0] result_hi_q, result_hi_d;

    logic        accept;
    logic        zero_path;
    logic [31:0] abs1, abs2;
    logic [64:0] shifted;
    logic [33:0] diff;
    logic [31:0] quot_mag, rem_mag;
    logic        ready;

    assign accept = (state_q == FREE) && bus.div_start && !bus.annul;

`ifdef DIV_ZERO_SKIP_EN
    assign zero_path = (bus.opdata2 == 32'd0) || (bus.opdata1 == 32'd0);
`else
    assign zero_path = (bus.opdata2 == 32'd0);
`endif

    // Magnitudes; 0x80000000 negates to itself and is then read as unsigned 2^31.
    assign abs1 = (bus.signed_div && bus.opdata1[31]) ? -bus.opdata1 : bus.opdata1;
    assign abs2 = (bus.signed_div && bus.opdata2[31]) ? -bus.opdata2 : bus.opdata2;

    // Partial remainder occupies [64:32] after the shift, so it never loses its top bit.
    assign shifted = work_q << 1;
    assign diff    = {1'b0, shifted[64:32]} - {2'b00, divisor_q};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FREE;
            cnt_q       <= 6'd0;
            work_q      <= 65'd0;
            divisor_q   <= 32'd0;
            signed_q    <= 1'b0;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            result_lo_q <= 32'd0;
            result_hi_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            work_q      <= work_d;
            divisor_q   <= divisor_d;
            signed_q    <= signed_d;
            sign1_q     <= sign1_d;
            sign2_q     <= sign2_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FREE:    if (accept) state_d = zero_path ? BYZERO : ON;
            BYZERO:  state_d = bus.annul ? FREE : END;
            ON: begin
                if (bus.annul)             state_d = FREE;
                else if (cnt_q == 6'd31)   state_d = END;
            end
            END:     state_d = FREE;
            default: state_d = FREE;
        endcase
    end

    always_comb begin
        cnt_d       = cnt_q;
        work_d      = work_q;
        divisor_d   = divisor_q;
        signed_d    = signed_q;
        sign1_d     = sign1_q;
        sign2_d     = sign2_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;

        case (state_q)
            FREE: begin
                if (accept) begin
                    signed_d  = bus.signed_div;
                    sign1_d   = bus.opdata1[31];
                    sign2_d   = bus.opdata2[31];
                    divisor_d = abs2;
                    cnt_d     = 6'd0;
                    work_d    = zero_path ? 65'd0 : {33'd0, abs1};
                end
            end
            BYZERO: work_d = 65'd0;
            ON: begin
                if (!bus.annul) begin
                    cnt_d  = cnt_q + 6'd1;
                    work_d = diff[33] ? shifted : {diff[32:0], shifted[31:1], 1'b1};
                end
            end
            default: ;
        endcase

        // Results are captured on entry to END so they are valid alongside ready.
        quot_mag = work_d[31:0];
        rem_mag  = work_d[63:32];
        if (state_d == END) begin
            result_lo_d = (signed_q && (sign1_q ^ sign2_q)) ? -quot_mag : quot_mag;
            result_hi_d = (signed_q && sign1_q) ? -rem_mag : rem_mag;
        end
    end

    assign ready               = (state_q == END);
    assign bus.ready           = ready;
    assign bus.result_lo       = result_lo_q;
    assign bus.result_hi       = result_hi_q;
    assign bus.stallreq_for_ex = bus.div_start & ~bus.annul & ~ready;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: scoreboard of expected quotient/remainder/latency,
// checked with immediate assertions when ready is observed.
module tb_div_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    div_unit_if bus ();

    div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [31:0] lo;
        logic [31:0] hi;
        int          lat;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] last_lo  = 32'd0;
    logic [31:0] last_hi  = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic start_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sd, q, r;
        e.a = a;
        e.b = b;
        if (b == 32'd0) begin
            e.lo = 32'd0; e.hi = 32'd0; e.lat = 2;
        end else if (sgn) begin
            sa = longint'($signed(a));
            sd = longint'($signed(b));
            q  = sa / sd;
            r  = sa % sd;
            e.lo = q[31:0]; e.hi = r[31:0]; e.lat = 33;
        end else begin
            e.lo = a / b; e.hi = a % b; e.lat = 33;
        end
`ifdef DIV_ZERO_SKIP_EN
        if (a == 32'd0 && b != 32'd0) e.lat = 2;
`endif
        sb.push_back(e);
        bus.div_start  = 1'b1;
        bus.signed_div = sgn;
        bus.opdata1    = a;
        bus.opdata2    = b;
    endtask

    // Called in the acceptance cycle T0; returns at the sample point of the ready cycle.
    task automatic wait_ready(input string tag, input int drop_at, input int annul_at);
        exp_t e;
        int   k;
        e = sb.pop_front();
        k = 0;
        while (k < 100) begin
            sample();
            if (bus.ready === 1'b1) break;
            check({tag, "_stall"}, 32'(bus.stallreq_for_ex), (k < drop_at) ? 32'd1 : 32'd0);
            tick();
            k++;
            if (k == drop_at)  bus.div_start = 1'b0;
            if (k == annul_at) bus.annul     = 1'b1;
        end
        check({tag, "_latency"}, 32'(k), 32'(e.lat));
        check({tag, "_lo"}, bus.result_lo, e.lo);
        check({tag, "_hi"}, bus.result_hi, e.hi);
        check({tag, "_stall_at_ready"}, 32'(bus.stallreq_for_ex), 32'd0);
        last_lo = e.lo;
        last_hi = e.hi;
        $display("txn %s a=%h b=%h lo=%h hi=%h latency=%0d", tag, e.a, e.b,
                 bus.result_lo, bus.result_hi, k);
    endtask

    task automatic finish_op(input string tag);
        tick();
        bus.div_start = 1'b0;
        bus.annul     = 1'b0;
        sample();
        check({tag, "_ready_drop"}, 32'(bus.ready), 32'd0);
        check({tag, "_lo_hold"}, bus.result_lo, last_lo);
        check({tag, "_hi_hold"}, bus.result_hi, last_hi);
    endtask

    task automatic run(input string tag, input bit sgn, input logic [31:0] a,
                       input logic [31:0] b, input int drop_at, input int annul_at);
        tick();
        start_op(sgn, a, b);
        wait_ready(tag, drop_at, annul_at);
        finish_op(tag);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.div_start = 1'b0; bus.signed_div = 1'b0; bus.annul = 1'b0;
        bus.opdata1 = 32'd0; bus.opdata2 = 32'd0;
        tick(); tick();
        sample();
        check("reset_ready", 32'(bus.ready), 32'd0);
        check("reset_lo", bus.result_lo, 32'd0);
        check("reset_hi", bus.result_hi, 32'd0);
        check("reset_stall", 32'(bus.stallreq_for_ex), 32'd0);
        $display("txn reset lo=%h hi=%h", bus.result_lo, bus.result_hi);
        tick();
        rst = 1'b0;

        run("divu_100_7", 1'b0, 32'd100, 32'd7, 1000, 1000);
        run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1000, 1000);
        run("div_ovf_annul_end", 1'b1, 32'h80000000, 32'hFFFFFFFF, 1000, 33);
        run("div_5_0", 1'b1, 32'd5, 32'd0, 1000, 1000);
        run("divu_0_9", 1'b0, 32'd0, 32'd9, 1000, 1000);
        run("divu_big_drop", 1'b0, 32'hFFFFFFFF, 32'h80000001, 5, 1000);
        run("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 1000, 1000);
        run("div_min_2", 1'b1, 32'h80000000, 32'd2, 1000, 1000);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom | 32'd1;
            run($sformatf("rand%0d", i), i[0], ra, rb, 1000, 1000);
        end

        // Flush in ON: drop at T10, idle at T11, new divu 9/3 at T12.
        tick();
        start_op(1'b0, 32'd100, 32'd7);
        repeat (10) tick();
        bus.annul = 1'b1;
        sample();
        check("annul_on_stall", 32'(bus.stallreq_for_ex), 32'd0);
        check("annul_on_ready", 32'(bus.ready), 32'd0);
        tick();
        bus.annul = 1'b0; bus.div_start = 1'b0;
        sample();
        check("annul_on_ready_t11", 32'(bus.ready), 32'd0);
        check("annul_on_lo_hold", bus.result_lo, last_lo);
        check("annul_on_hi_hold", bus.result_hi, last_hi);
        $display("txn annul_on lo=%h hi=%h", bus.result_lo, bus.result_hi);
        void'(sb.pop_front());
        run("divu_9_3_after_annul", 1'b0, 32'd9, 32'd3, 1000, 1000);

        // Flush in BYZERO: no ready pulse, results kept.
        tick();
        start_op(1'b1, 32'd5, 32'd0);
        tick();
        bus.annul = 1'b1; bus.div_start = 1'b0;
        sample();
        check("annul_bz_ready_t1", 32'(bus.ready), 32'd0);
        tick();
        bus.annul = 1'b0;
        sample();
        check("annul_bz_ready_t2", 32'(bus.ready), 32'd0);
        check("annul_bz_lo_hold", bus.result_lo, last_lo);
        check("annul_bz_hi_hold", bus.result_hi, last_hi);
        $display("txn annul_byzero lo=%h hi=%h", bus.result_lo, bus.result_hi);
        void'(sb.pop_front());

        // Reset at T15 of an operation.
        tick();
        start_op(1'b0, 32'd100, 32'd7);
        repeat (15) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; bus.div_start = 1'b0;
        sample();
        check("midrst_ready", 32'(bus.ready), 32'd0);
        check("midrst_lo", bus.result_lo, 32'd0);
        check("midrst_hi", bus.result_hi, 32'd0);
        $display("txn midop_reset lo=%h hi=%h", bus.result_lo, bus.result_hi);
        void'(sb.pop_front());
        last_lo = 32'd0;
        last_hi = 32'd0;
        sample();
        check("midrst_no_ready", 32'(bus.ready), 32'd0);

        // Back-to-back: second accepted the cycle after the first ready (T33 -> T67).
        tick();
        start_op(1'b0, 32'd8, 32'd2);
        wait_ready("b2b_8_2", 1000, 1000);
        tick();
        start_op(1'b0, 32'd9, 32'd4);
        wait_ready("b2b_9_4", 1000, 1000);
        finish_op("b2b_9_4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
